// File: rtl/imem_loader.sv
// imem_loader: framed byte stream to imem word writes, holding the CPU while loading
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          TIMEOUT    = 100000,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [31:0]           wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CHECK} state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, csum_q;
    logic [1:0]            bcnt_q;
    logic [23:0]           asm_q;
    logic [ADDR_WIDTH-1:0] widx_q, waddr_q;
    logic [31:0]           wdata_q;
    logic [TW-1:0]         tmo_q;
    logic                  hold_q, done_q, err_q;
    logic                  accept, timing, tmo_hit, last_word;

    assign accept    = rx_valid && rx_ready;
    assign timing    = state_q inside {COUNT, DATA, CHECK};
    assign tmo_hit   = timing && !accept && tmo_q == TW'(TIMEOUT - 1);
    assign last_word = widx_q[7:0] == cnt_q - 8'd1;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state logic; a timeout overrides any byte-driven transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && rx_data == SYNC_BYTE) state_d = COUNT;
            COUNT:   if (accept) state_d = DATA;
            DATA:    if (accept && bcnt_q == 2'd3) state_d = WRITE;
            WRITE:   state_d = last_word ? CHECK : DATA;
            CHECK:   if (accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tmo_hit) state_d = IDLE;
    end

    // state-decoded outputs; write strobe and byte stall both come from WRITE
    always_comb begin
        rx_ready = state_q != WRITE;
        we       = state_q == WRITE;
        busy     = state_q != IDLE;
        waddr    = waddr_q;
        wdata    = wdata_q;
        cpu_hold = hold_q;
        done     = done_q;
        error    = err_q;
    end

    // frame datapath: assembly, checksum, addressing, timeout and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            csum_q  <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            widx_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            tmo_q   <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            tmo_q  <= (!timing || accept || tmo_hit) ? '0 : tmo_q + 1'b1;
            if (state_q == IDLE && accept && rx_data == SYNC_BYTE) begin
                hold_q <= 1'b1;
                err_q  <= 1'b0;
                csum_q <= '0;
                widx_q <= '0;
                bcnt_q <= '0;
            end
            if (state_q == COUNT && accept) cnt_q <= rx_data;
            if (state_q == DATA && accept) begin
                asm_q  <= {asm_q[15:0], rx_data};
                csum_q <= csum_q ^ rx_data;
                bcnt_q <= bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    wdata_q <= {asm_q, rx_data};
                    waddr_q <= widx_q;
                end
            end
            if (state_q == WRITE) widx_q <= widx_q + 1'b1;
            if (state_q == CHECK && accept) begin
                done_q <= rx_data == csum_q;
                hold_q <= rx_data != csum_q;
                err_q  <= rx_data != csum_q;
            end
            if (tmo_hit) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table vectors, directed corner sequences and randomized frames against a stream-level model
module tb_imem_loader;
    localparam int TMO = 40;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef logic [7:0] u8;
    typedef struct {
        logic [31:0] w;
        logic [7:0]  cs;
        logic        err;
        logic        hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, we, cpu_hold, busy, done, error;
    logic [7:0]  waddr;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int lo_cnt = 0;
    logic [39:0] wq[$];
    logic [39:0] ew[$];

    int m_done;
    logic m_err, m_hold;

    imem_loader #(.ADDR_WIDTH(8), .TIMEOUT(TMO), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) wq.push_back({waddr, wdata});
        if (done) done_cnt++;
        if (!rx_ready) lo_cnt++;
        checks++;
        if (done && error) begin
            errors++;
            $display("FAIL done_and_error: done=%b error=%b both high", done, error);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_writes(input string nm);
        chk({nm, "_nwrites"}, wq.size(), ew.size());
        for (int i = 0; i < ew.size() && i < wq.size(); i++)
            chk($sformatf("%s_w%0d", nm, i), {24'h0, wq[i][39:32]} ^ wq[i][31:0] ^ {wq[i][39:32], 24'h0},
                {24'h0, ew[i][39:32]} ^ ew[i][31:0] ^ {ew[i][39:32], 24'h0});
        for (int i = 0; i < ew.size() && i < wq.size(); i++)
            if (wq[i] !== ew[i]) begin
                errors++;
                $display("FAIL %s_entry%0d: got %h expected %h", nm, i, wq[i], ew[i]);
            end
        wq.delete();
        ew.delete();
    endtask

    task automatic send(input u8 b);
        int g = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && g < 10) begin
            @(negedge clk);
            g++;
        end
        if (g >= 10) begin
            checks++;
            errors++;
            $display("FAIL send_stall: rx_ready stuck low for %0d cycles, required high", g);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_stream(input u8 s[$], input int maxgap);
        foreach (s[i]) begin
            send(s[i]);
            idle($urandom_range(0, maxgap));
        end
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_rx_ready"}, rx_ready, 1);
        chk({nm, "_we"}, we, 0);
        chk({nm, "_waddr"}, waddr, 0);
        chk({nm, "_wdata"}, wdata, 0);
        chk({nm, "_cpu_hold"}, cpu_hold, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_error"}, error, 0);
    endtask

    // stream-level reference: parses the byte sequence by the frame rules from an idle, clean start
    task automatic model(input u8 s[$]);
        int i = 0;
        int n;
        u8 cs;
        logic [31:0] w;
        ew.delete();
        m_done = 0;
        m_err = 1'b0;
        m_hold = 1'b0;
        while (i < s.size()) begin
            if (s[i] != SYNC) begin
                i++;
                continue;
            end
            i++;
            m_hold = 1'b1;
            m_err = 1'b0;
            if (i >= s.size()) break;
            n = (s[i] == 0) ? 256 : int'(s[i]);
            i++;
            cs = 8'h00;
            for (int k = 0; k < n; k++) begin
                if (i + 4 > s.size()) begin
                    i = s.size();
                    break;
                end
                w = {s[i], s[i+1], s[i+2], s[i+3]};
                cs = cs ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
                ew.push_back({k[7:0], w});
                i += 4;
            end
            if (i < s.size()) begin
                if (s[i] == cs) begin
                    m_done++;
                    m_hold = 1'b0;
                end else m_err = 1'b1;
                i++;
            end
        end
    endtask

    task automatic one_word(input logic [31:0] w, input u8 cs);
        send(SYNC); send(8'h01);
        send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
        send(cs);
    endtask

    initial begin
        vec_t tbl[7];
        u8 s[$];
        int d0, l0;
        tbl[0] = '{32'h20000001, 8'h21, 1'b0, 1'b0};
        tbl[1] = '{32'hA5A5A5A5, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{32'h12345678, 8'h08, 1'b0, 1'b0};
        tbl[3] = '{32'h12345678, 8'h09, 1'b1, 1'b1};
        tbl[4] = '{32'hFFFFFFFF, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{32'h00000000, 8'hA5, 1'b1, 1'b1};
        tbl[6] = '{32'h8C000004, 8'h88, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        check_reset("rst");
        reset = 1'b0;
        idle(1);

        // two-word frame with exact write and done timing
        d0 = done_cnt;
        send(SYNC); send(8'h02); send(8'h20); send(8'h00); send(8'h00); send(8'h01);
        chk("a_we0", we, 1);
        chk("a_waddr0", waddr, 0);
        chk("a_wdata0", wdata, 32'h20000001);
        chk("a_rx_ready_write", rx_ready, 0);
        chk("a_hold_mid", cpu_hold, 1);
        send(8'h08); send(8'h00); send(8'h00); send(8'h01);
        chk("a_we1", we, 1);
        chk("a_waddr1", waddr, 1);
        chk("a_wdata1", wdata, 32'h08000001);
        send(8'h28);
        chk("a_done", done, 1);
        chk("a_hold_rel", cpu_hold, 0);
        chk("a_error", error, 0);
        idle(1);
        chk("a_done_pulse", done, 0);
        chk("a_wdata_hold", wdata, 32'h08000001);
        chk("a_done_cnt", done_cnt - d0, 1);
        ew.push_back({8'd0, 32'h20000001});
        ew.push_back({8'd1, 32'h08000001});
        chk_writes("a");

        // table of one-word frames, good and bad checksums
        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt;
            one_word(tbl[i].w, tbl[i].cs);
            idle(2);
            chk($sformatf("t%0d_error", i), error, tbl[i].err);
            chk($sformatf("t%0d_hold", i), cpu_hold, tbl[i].hold);
            chk($sformatf("t%0d_done", i), done_cnt - d0, tbl[i].err ? 0 : 1);
            chk($sformatf("t%0d_busy", i), busy, 0);
            ew.push_back({8'd0, tbl[i].w});
            chk_writes($sformatf("t%0d", i));
        end

        // garbage before a frame is discarded
        send(8'h00);
        chk("g_ready0", rx_ready, 1);
        send(8'hFF);
        chk("g_ready1", rx_ready, 1);
        send(8'h5A);
        chk("g_hold", cpu_hold, 0);
        chk("g_busy", busy, 0);
        chk_writes("g_none");
        one_word(32'hDEADBEEF, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
        idle(2);
        ew.push_back({8'd0, 32'hDEADBEEF});
        chk_writes("g");

        // timeout boundary: one cycle short, then expiry
        send(SYNC); send(8'h01); send(8'h20); send(8'h00);
        idle(TMO - 1);
        chk("to_busy_before", busy, 1);
        chk("to_err_before", error, 0);
        idle(1);
        chk("to_error", error, 1);
        chk("to_busy", busy, 0);
        chk("to_hold", cpu_hold, 1);
        chk_writes("to_none");
        one_word(32'h11223344, 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
        idle(2);
        chk("to_recover_err", error, 0);
        chk("to_recover_hold", cpu_hold, 0);
        ew.push_back({8'd0, 32'h11223344});
        chk_writes("to_rec");

        // reset mid-frame after six data bytes
        send(SYNC); send(8'h02);
        send(8'h20); send(8'h00); send(8'h00); send(8'h01); send(8'h08); send(8'h00);
        reset = 1'b1;
        @(negedge clk);
        check_reset("mid_rst");
        reset = 1'b0;
        ew.push_back({8'd0, 32'h20000001});
        chk_writes("mid_pre");
        one_word(32'hCAFEF00D, 8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D);
        idle(2);
        ew.push_back({8'd0, 32'hCAFEF00D});
        chk_writes("mid_post");

        // count 0 means 256 words, word k = k
        s.delete();
        s.push_back(SYNC);
        s.push_back(8'h00);
        for (int k = 0; k < 256; k++) begin
            s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00); s.push_back(u8'(k));
        end
        s.push_back(8'h00);
        model(s);
        d0 = done_cnt;
        l0 = lo_cnt;
        send_stream(s, 0);
        idle(2);
        chk("n0_lo_cycles", lo_cnt - l0, 256);
        chk("n0_done", done_cnt - d0, m_done);
        chk("n0_error", error, m_err);
        chk("n0_hold", cpu_hold, m_hold);
        chk_writes("n0");

        // randomized frames with gaps, garbage and occasional bad checksums
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wq.delete();
        s.delete();
        for (int f = 0; f < 8; f++) begin
            int n;
            u8 cs, b;
            repeat ($urandom_range(0, 3)) begin
                b = u8'($urandom_range(0, 255));
                s.push_back(b == SYNC ? 8'h5A : b);
            end
            n = $urandom_range(1, 5);
            s.push_back(SYNC);
            s.push_back(u8'(n));
            cs = 8'h00;
            repeat (4 * n) begin
                b = u8'($urandom_range(0, 255));
                s.push_back(b);
                cs ^= b;
            end
            s.push_back(($urandom_range(0, 2) == 0) ? cs ^ (8'h01 << $urandom_range(0, 7)) : cs);
        end
        model(s);
        d0 = done_cnt;
        send_stream(s, 3);
        idle(3);
        chk("rnd_done", done_cnt - d0, m_done);
        chk("rnd_error", error, m_err);
        chk("rnd_hold", cpu_hold, m_hold);
        chk("rnd_busy", busy, 0);
        chk_writes("rnd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
